program_loader: RTL
===================

Name: program_loader

Overview:
- Writer for the BIP instruction memory; the write side of the read-only program memory.
- Receives a byte stream from the UART receiver, assembles 16-bit instructions and writes them to sequential addresses.
- Holds the CPU in reset during loading and releases it once the declared number of words has been written.

Parameters:
- RAM_WIDTH, 16, instruction width in bits; fixed at 2 bytes per word.
- RAM_DEPTH, 2048, number of memory entries; address width AW = clogb2(RAM_DEPTH-1), 11 at default.
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes while a load is in progress; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid while it is high.
- i_reload  in  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
- o_wr_en  out  1  memory write strobe, one cycle per word.
- o_wr_addr  out  AW  memory write address.
- o_wr_data  out  RAM_WIDTH  memory write data.
- o_busy  out  1  high while a load is in progress (header or data).
- o_done  out  1  high when the load completed successfully.
- o_error  out  1  high when the load aborted.
- o_cpu_rst  out  1  CPU reset; high except in DONE.

Behaviour:
- Reset: one clock (i_clk); reset is asynchronous and active-high (i_rst). All outputs are registered. Reset values: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_error=0, o_cpu_rst=1. State goes to IDLE; word counter and timeout counter clear to 0.
- Stream format: 16-bit word count N, MSB byte first, then N words, each MSB byte first.
- States and transitions:
  - IDLE: a byte is latched as N[15:8]; go to CNT_LO. o_busy=1 from the next cycle.
  - CNT_LO: a byte is latched as N[7:0].
    - N == 0: go to DONE.
    - N > RAM_DEPTH: go to ERROR; no write is issued.
    - Otherwise: go to DATA_HI.
  - DATA_HI: a byte is latched into the high byte of the word; go to DATA_LO.
  - DATA_LO: on a byte, the cycle after the accepting edge shows o_wr_en=1, o_wr_data={hi,byte}, o_wr_addr=word index. The index starts at 0 and increments after each write.
    - If this was word N: go to DONE. o_done rises and o_cpu_rst falls in the same cycle as the final o_wr_en pulse is deasserted, i.e. one cycle after the last write.
    - Otherwise: go back to DATA_HI.
  - DONE: o_done=1, o_cpu_rst=0, o_busy=0. Bytes are ignored. i_reload goes to IDLE: o_done=0, o_cpu_rst=1, addresses reset to 0.
  - ERROR: o_error=1, o_cpu_rst=1, o_busy=0. Bytes are ignored. i_reload goes to IDLE and clears o_error.
- i_reload in IDLE, CNT_LO, DATA_HI or DATA_LO: ignored.
- Timeout:
  - The counter runs only in CNT_LO, DATA_HI and DATA_LO, and clears on every i_rx_valid.
  - When it reaches TIMEOUT_CYCLES: go to ERROR. A partially assembled word is discarded and not written.
- Only one byte can be accepted per cycle, so no byte is ever dropped except in DONE or ERROR.
- o_wr_addr holds its last value between writes; o_wr_data likewise.
- Reset mid-load: immediate return to reset values. Memory contents already written are left as they are.
- N == RAM_DEPTH is legal; the last write goes to address RAM_DEPTH-1, and the address never wraps.

Decomposition:
- Shared package (bip_pkg):
  - state encoding enum (IDLE, CNT_LO, DATA_HI, DATA_LO, DONE, ERROR);
  - BYTES_PER_WORD = 2;
  - clogb2 function, shared with the program memory.
- One sub-module, loader_timeout: a counter with clear/enable inputs and a TIMEOUT_CYCLES parameter, producing a one-cycle o_expired pulse. It is tied off when TIMEOUT_CYCLES = 0.

Test Plan:
1. Send 00 03 | 12 34 | AB CD | 00 01 -> three o_wr_en pulses: (0,0x1234), (1,0xABCD), (2,0x0001). o_done=1 and o_cpu_rst=0 one cycle after the third pulse; o_busy low again.
2. Send 00 00 -> no o_wr_en; o_done=1 the cycle after the second byte. A later byte 0xFF produces no write.
3. Send 08 01 (N=2049) -> o_error=1, no writes, o_cpu_rst stays 1. Then i_reload and the scenario 1 stream -> correct load from address 0.
4. With TIMEOUT_CYCLES=50: send 00 02 12 then idle 50 cycles -> o_error=1, no write. A byte at cycle 49 instead restarts the count and the load continues.
5. After DONE: i_reload, then 00 01 BE EF -> o_cpu_rst=1 during the reload; single write (0,0xBEEF); o_done=1 again.
6. Assert i_rst between the two bytes of word 1 in scenario 1 -> all outputs return to reset values within the same cycle (asynchronous). The subsequent full stream loads from address 0.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP program memory and its loader.
package bip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 2;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int res;
    v   = value;
    res = 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for the program loader: a one-cycle o_expired pulse once
// TIMEOUT_CYCLES enabled cycles pass without a clear.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_count;
  logic          r_expired;
  logic          w_hit;

  assign w_hit = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= w_hit;
      if (!i_enable || i_clear || w_hit) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign o_expired = r_expired;

endmodule

// File: rtl/program_loader.sv
// Write side of the BIP program memory: assembles a word-count-prefixed byte
// stream into 16-bit instructions and holds the CPU in reset until loading ends.
module program_loader
  import bip_pkg::*;
#(
  parameter int unsigned RAM_WIDTH      = 16,
  parameter int unsigned RAM_DEPTH      = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int         AW             = (clogb2(int'(RAM_DEPTH) - 1) < 1) ? 1 :
                                           clogb2(int'(RAM_DEPTH) - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_reload,
  output logic                 o_wr_en,
  output logic [AW-1:0]        o_wr_addr,
  output logic [RAM_WIDTH-1:0] o_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_cpu_rst
);

  localparam int CNT_W = BYTES_PER_WORD * 8;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_W-1:0]     r_count;
  logic [7:0]           r_hi;
  logic [AW:0]          r_word_idx;
  logic                 r_wr_en;
  logic [AW-1:0]        r_wr_addr;
  logic [RAM_WIDTH-1:0] r_wr_data;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
  logic                 r_cpu_rst;

  logic                 w_write;
  logic                 w_last;
  logic                 w_loading;
  logic                 w_expired;
  logic [CNT_W-1:0]     w_n;
  logic                 w_reload_ok;

  assign w_n         = {r_count[CNT_W-1:8], i_rx_data};
  assign w_loading   = (r_state == CNT_LO) || (r_state == DATA_HI) || (r_state == DATA_LO);
  assign w_reload_ok = i_reload && ((r_state == DONE) || (r_state == ERROR));

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign w_expired = 1'b0;
    end else begin : g_timeout
      loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (i_rx_valid),
        .i_enable (w_loading),
        .o_expired(w_expired)
      );
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Timeout takes priority over a byte arriving in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_write      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_valid) w_next_state = CNT_LO;
      end
      CNT_LO: begin
        if (w_expired) begin
          w_next_state = ERROR;
        end else if (i_rx_valid) begin
          if (w_n == '0) begin
            w_next_state = DONE;
          end else if (32'(w_n) > RAM_DEPTH) begin
            w_next_state = ERROR;
          end else begin
            w_next_state = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (w_expired) begin
          w_next_state = ERROR;
        end else if (i_rx_valid) begin
          w_next_state = DATA_LO;
        end
      end
      DATA_LO: begin
        if (w_expired) begin
          w_next_state = ERROR;
        end else if (i_rx_valid) begin
          w_write = 1'b1;
          if (32'(r_word_idx) + 32'd1 == 32'(r_count)) begin
            w_last       = 1'b1;
            w_next_state = DONE;
          end else begin
            w_next_state = DATA_HI;
          end
        end
      end
      DONE, ERROR: begin
        if (i_reload) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Status flags follow the next state, except that DONE is withheld while the
  // final write strobe is still on the bus.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count    <= '0;
      r_hi       <= '0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_wr_en <= w_write;
      if ((r_state == IDLE) && i_rx_valid) begin
        r_count[CNT_W-1:8] <= i_rx_data;
      end
      if ((r_state == CNT_LO) && i_rx_valid && !w_expired) begin
        r_count[7:0] <= i_rx_data;
      end
      if ((r_state == DATA_HI) && i_rx_valid && !w_expired) begin
        r_hi <= i_rx_data;
      end
      if (w_write) begin
        r_wr_addr  <= r_word_idx[AW-1:0];
        r_wr_data  <= {r_hi, i_rx_data};
        r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_reload_ok) begin
        r_wr_addr  <= '0;
        r_word_idx <= '0;
      end
      r_busy    <= (w_next_state == CNT_LO) || (w_next_state == DATA_HI) ||
                   (w_next_state == DATA_LO) || w_last;
      r_done    <= (w_next_state == DONE) && !w_last;
      r_error   <= (w_next_state == ERROR);
      r_cpu_rst <= !((w_next_state == DONE) && !w_last);
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_cpu_rst = r_cpu_rst;

endmodule
